change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Back-end actuator for the vending controller. It consumes the controller's purchase flag and 2-bit cash_return refund code, then drives the item-release solenoid and the 5-unit coin ejector.
- Each refund request expands into timed pulse trains: one item-release pulse if a purchase occurred, then N coin-eject pulses, where N is the refund code (0..3 coins of 5 units).
- It tracks total coins paid out and latches a fault on an empty hopper.

Parameters:
- PULSE_CYCLES, 2, cycles item_release / coin_eject are held high per actuation (>=1)
- GAP_CYCLES, 3, low cycles inserted between consecutive actuations (>=1)
- CNT_W, 8, width of coins_paid counter

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- refund_valid  input  1  one-cycle strobe: purchase/cash_return are valid this cycle
- purchase  input  1  1 = release one item
- cash_return  input  2  coins to return: 00=R0, 01=R5, 10=R10, 11=R15
- hopper_empty  input  1  coin hopper sensor, 1 = no coins available
- busy  output  1  1 while a request is being serviced
- item_release  output  1  item solenoid drive
- coin_eject  output  1  coin ejector drive, one pulse per coin
- refund_done  output  1  one-cycle pulse at completion of a request
- req_dropped  output  1  one-cycle pulse: refund_valid arrived while busy
- fault  output  1  sticky: hopper empty when a coin was due
- coins_paid  output  CNT_W  total coins ejected since reset, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-pulse) forces state IDLE and clears the internal coin counter. All outputs are 0, and coins_paid=0, from the cycle after reset is sampled.
- States: IDLE, RELEASE, EJECT, GAP, DONE, FAULT. A down-counter times the PULSE_CYCLES and GAP_CYCLES intervals.
- IDLE:
  - refund_valid=1 at edge E captures purchase and coins=cash_return.
  - Next state from E+1: RELEASE if purchase=1; else EJECT if coins>0; else DONE.
  - busy=1 from the cycle after E through the DONE cycle inclusive.
- RELEASE:
  - item_release=1 for exactly PULSE_CYCLES cycles.
  - Then EJECT if coins>0, else DONE. No gap between RELEASE and the first EJECT.
- EJECT entry check:
  - hopper_empty is sampled on the edge that would enter EJECT.
  - If it is 1, go to FAULT instead; coin_eject never rises.
- EJECT:
  - coin_eject=1 for PULSE_CYCLES cycles.
  - On the final cycle: coins decrements and coins_paid increments by 1.
  - Then GAP if coins (after decrement) >0, else DONE.
- GAP:
  - All drives low for GAP_CYCLES cycles, then EJECT (with the hopper check).
- DONE:
  - refund_done=1 and busy=1 for one cycle, then IDLE.
  - A new request can be captured in the first IDLE cycle.
- FAULT:
  - fault=1, busy=1, item_release=0, coin_eject=0.
  - Remaining coins are abandoned; refund_done is never pulsed.
  - Held until reset.
- req_dropped:
  - refund_valid=1 in any non-IDLE state (including DONE and FAULT) is ignored.
  - req_dropped pulses high the next cycle.
- hopper_empty changing during an EJECT pulse or a GAP has no effect until the next EJECT entry.
- item_release and coin_eject are never high in the same cycle.
- Inputs are sampled only as stated above.

Test Plan:
- Reset mid-operation: hold reset 2 cycles during an EJECT pulse -> next cycle all outputs 0, coins_paid=0; refund_valid right after reset deasserts is serviced normally.
- Coins only: refund_valid with purchase=0, cash_return=10 at E0 (defaults) -> coin_eject high cycles 1-2 and 6-7, low 3-5, refund_done at cycle 8, busy cycles 1-8, coins_paid=2.
- Purchase plus coins: purchase=1, cash_return=11 -> item_release cycles 1-2, coin_eject cycles 3-4, 8-9, 13-14, refund_done cycle 15, coins_paid=3.
- Purchase, no change: purchase=1, cash_return=00 -> item_release cycles 1-2, refund_done cycle 3, coin_eject never high. Null request (0,00) -> refund_done cycle 1 only.
- Empty hopper: cash_return=11, hopper_empty raised during the first GAP -> one coin ejected, fault=1 from cycle 6 and stays, no refund_done, coins_paid=1 until reset.
- Overrun and back-to-back: refund_valid during busy -> req_dropped one cycle later, request ignored. New request in the first IDLE after DONE -> accepted; coins_paid wraps 255->0 with CNT_W=8.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request and actuator bundle between the vending controller and the change dispenser.
// The controller drives the request side through `master`; the dispenser uses `slave`.
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             refund_valid;
  logic             purchase;
  logic [1:0]       cash_return;
  logic             hopper_empty;
  logic             busy;
  logic             item_release;
  logic             coin_eject;
  logic             refund_done;
  logic             req_dropped;
  logic             fault;
  logic [CNT_W-1:0] coins_paid;

  modport master (
    output refund_valid, purchase, cash_return, hopper_empty,
    input  busy, item_release, coin_eject, refund_done, req_dropped, fault, coins_paid
  );

  modport slave (
    input  refund_valid, purchase, cash_return, hopper_empty,
    output busy, item_release, coin_eject, refund_done, req_dropped, fault, coins_paid
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: expands a purchase/refund request into timed item-release and
// coin-eject pulse trains, counts coins paid and latches a fault on an empty hopper.
module change_dispenser #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3,
  parameter int CNT_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  change_dispenser_if.slave   bus
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_e;

  // State, interval timer and every drive that is a pure function of the state.
  typedef struct packed {
    state_e        state;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          item_release;
    logic          coin_eject;
    logic          refund_done;
    logic          fault;
  } ctl_t;

  ctl_t             ctl;
  logic [1:0]       coins;
  logic [CNT_W-1:0] coins_paid;
  logic             req_dropped;

  // Entering a state loads its timer and the drives it holds for its whole duration,
  // so every output is registered together with the state it belongs to.
  function automatic ctl_t enter(state_e s);
    ctl_t c;
    c       = '0;
    c.state = s;
    c.busy  = (s != S_IDLE);
    case (s)
      S_RELEASE: begin
        c.item_release = 1'b1;
        c.cnt          = CW'(PULSE_CYCLES - 1);
      end
      S_EJECT: begin
        c.coin_eject = 1'b1;
        c.cnt        = CW'(PULSE_CYCLES - 1);
      end
      S_GAP:   c.cnt         = CW'(GAP_CYCLES - 1);
      S_DONE:  c.refund_done = 1'b1;
      S_FAULT: c.fault       = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every branch reads
  // the pre-edge values of ctl, coins and coins_paid.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctl         <= enter(S_IDLE);
      coins       <= 2'd0;
      coins_paid  <= '0;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= bus.refund_valid && (ctl.state != S_IDLE);

      case (ctl.state)
        S_IDLE: begin
          if (bus.refund_valid) begin
            coins <= bus.cash_return;
            if (bus.purchase)
              ctl <= enter(S_RELEASE);
            else if (bus.cash_return != 2'd0)
              ctl <= enter(bus.hopper_empty ? S_FAULT : S_EJECT);
            else
              ctl <= enter(S_DONE);
          end
        end

        S_RELEASE: begin
          if (ctl.cnt != '0)
            ctl.cnt <= ctl.cnt - CW'(1);
          else if (coins != 2'd0)
            ctl <= enter(bus.hopper_empty ? S_FAULT : S_EJECT);
          else
            ctl <= enter(S_DONE);
        end

        S_EJECT: begin
          if (ctl.cnt != '0) begin
            ctl.cnt <= ctl.cnt - CW'(1);
          end else begin
            coins      <= coins - 2'd1;
            coins_paid <= coins_paid + CNT_W'(1);
            ctl        <= enter((coins > 2'd1) ? S_GAP : S_DONE);
          end
        end

        S_GAP: begin
          if (ctl.cnt != '0)
            ctl.cnt <= ctl.cnt - CW'(1);
          else
            ctl <= enter(bus.hopper_empty ? S_FAULT : S_EJECT);
        end

        S_DONE:  ctl <= enter(S_IDLE);

        // Remaining coins are abandoned; only reset leaves this state.
        S_FAULT: ctl <= ctl;

        default: ctl <= enter(S_IDLE);
      endcase
    end
  end

  assign bus.busy         = ctl.busy;
  assign bus.item_release = ctl.item_release;
  assign bus.coin_eject   = ctl.coin_eject;
  assign bus.refund_done  = ctl.refund_done;
  assign bus.fault        = ctl.fault;
  assign bus.req_dropped  = req_dropped;
  assign bus.coins_paid   = coins_paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table-driven request vectors with per-cycle
// expected drive masks, plus hand-written overrun, reset, wrap and empty-hopper sequences.
module tb_change_dispenser;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  change_dispenser_if #(.CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .PULSE_CYCLES(2),
    .GAP_CYCLES  (3),
    .CNT_W       (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        p;
    logic [1:0]  c;
    logic [31:0] item_m;  // bit k set: item_release high in cycle k after capture
    logic [31:0] coin_m;  // bit k set: coin_eject high in cycle k after capture
    int          done;    // cycle of the refund_done pulse
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_paid = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle 1 after capture.
  task automatic launch(input logic p, input logic [1:0] c);
    bus.refund_valid = 1'b1;
    bus.purchase     = p;
    bus.cash_return  = c;
    tick();
    bus.refund_valid = 1'b0;
    bus.purchase     = 1'b0;
    bus.cash_return  = 2'd0;
  endtask

  // Full request with a bounded wait for refund_done; returns in the first idle cycle.
  task automatic serve(input logic p, input logic [1:0] c);
    int k;
    launch(p, c);
    k = 1;
    while (!bus.refund_done && k < 40) begin
      tick();
      k++;
    end
    check("serve_done", 32'(bus.refund_done), 32'd1);
    exp_paid += int'(c);
    tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.busy, bus.item_release, bus.coin_eject, bus.refund_done,
            bus.req_dropped, bus.fault, bus.coins_paid};
  endfunction

  initial begin
    logic seen;

    vecs[0] = '{p: 1'b0, c: 2'b10, item_m: 32'h0,   coin_m: 32'h00C6, done: 8};
    vecs[1] = '{p: 1'b1, c: 2'b11, item_m: 32'h6,   coin_m: 32'h6318, done: 15};
    vecs[2] = '{p: 1'b1, c: 2'b00, item_m: 32'h6,   coin_m: 32'h0,    done: 3};
    vecs[3] = '{p: 1'b0, c: 2'b00, item_m: 32'h0,   coin_m: 32'h0,    done: 1};
    vecs[4] = '{p: 1'b0, c: 2'b01, item_m: 32'h0,   coin_m: 32'h6,    done: 3};
    vecs[5] = '{p: 1'b1, c: 2'b01, item_m: 32'h6,   coin_m: 32'h18,   done: 5};

    reset            = 1'b1;
    bus.refund_valid = 1'b0;
    bus.purchase     = 1'b0;
    bus.cash_return  = 2'd0;
    bus.hopper_empty = 1'b0;
    tick();
    tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Table vectors, each launched in the first idle cycle after the previous one.
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].p, vecs[i].c);
      for (int k = 1; k <= vecs[i].done; k++) begin
        if (k > 1) tick();
        check($sformatf("vec%0d_cyc%0d", i, k),
              {28'd0, bus.busy, bus.item_release, bus.coin_eject, bus.refund_done},
              {28'd0, 1'b1, vecs[i].item_m[k], vecs[i].coin_m[k], (k == vecs[i].done)});
      end
      exp_paid += int'(vecs[i].c);
      tick();
      check($sformatf("vec%0d_idle", i),
            {28'd0, bus.busy, bus.item_release, bus.coin_eject, bus.refund_done}, 32'd0);
      check($sformatf("vec%0d_paid", i), 32'(bus.coins_paid), 32'(CNT_W'(exp_paid)));
    end

    // Overrun: a request during a GAP and one during DONE are both dropped.
    launch(1'b0, 2'b11);
    tick();
    tick();
    bus.refund_valid = 1'b1;
    bus.purchase     = 1'b1;
    bus.cash_return  = 2'b11;
    tick();
    bus.refund_valid = 1'b0;
    check("overrun_dropped", 32'(bus.req_dropped), 32'd1);
    seen = 1'b0;
    for (int k = 5; k <= 13; k++) begin
      tick();
      if (k == 5) check("overrun_drop_pulse", 32'(bus.req_dropped), 32'd0);
      seen |= bus.item_release;
    end
    check("overrun_no_item", 32'(seen), 32'd0);
    check("overrun_done13", 32'(bus.refund_done), 32'd1);
    bus.refund_valid = 1'b1;
    tick();
    bus.refund_valid = 1'b0;
    bus.purchase     = 1'b0;
    bus.cash_return  = 2'd0;
    exp_paid += 3;
    check("done_drop", {30'd0, bus.req_dropped, bus.busy}, 32'b10);
    check("overrun_paid", 32'(bus.coins_paid), 32'(CNT_W'(exp_paid)));
    tick();
    check("done_drop_ignored", 32'(bus.busy), 32'd0);

    // Reset held for two edges during an EJECT pulse.
    launch(1'b0, 2'b10);
    check("midop_ejecting", 32'(bus.coin_eject), 32'd1);
    reset = 1'b1;
    tick();
    check("midop_reset_outputs", all_outs(), 32'd0);
    tick();
    reset    = 1'b0;
    exp_paid = 0;
    launch(1'b1, 2'b00);
    check("post_reset_item", {30'd0, bus.busy, bus.item_release}, 32'b11);
    tick();
    tick();
    check("post_reset_done", 32'(bus.refund_done), 32'd1);
    tick();

    // Counter wrap: 255 coins, then one more wraps to zero.
    for (int i = 0; i < 85; i++) serve(1'b0, 2'b11);
    check("paid_255", 32'(bus.coins_paid), 32'd255);
    serve(1'b0, 2'b01);
    check("paid_wrap", 32'(bus.coins_paid), 32'd0);

    // Empty hopper raised during the first GAP.
    launch(1'b0, 2'b11);
    tick();
    tick();
    bus.hopper_empty = 1'b1;
    tick();
    tick();
    tick();
    exp_paid += 1;
    check("fault_cyc6", {29'd0, bus.fault, bus.busy, bus.coin_eject}, 32'b110);
    check("fault_paid", 32'(bus.coins_paid), 32'(CNT_W'(exp_paid)));
    bus.refund_valid = 1'b1;
    tick();
    bus.refund_valid = 1'b0;
    bus.hopper_empty = 1'b0;
    check("fault_drop", 32'(bus.req_dropped), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen |= bus.refund_done | bus.coin_eject | bus.item_release | ~bus.fault;
    end
    check("fault_sticky", 32'(seen), 32'd0);
    check("fault_paid_hold", 32'(bus.coins_paid), 32'(CNT_W'(exp_paid)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("fault_reset", all_outs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
